// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding and client codes.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StServeI = 2'd1,
      StServeD = 2'd2
   } arb_state_e;

   typedef enum logic {
      ClientI = 1'b0,
      ClientD = 1'b1
   } client_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch client, data client and backend memory port of the arbiter.
interface mem_arbiter_if #(
   parameter int unsigned AW = 16,
   parameter int unsigned DW = 16
) ();

   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_flush;
   logic          if_done;
   logic [DW-1:0] if_rdata;
   logic          if_stall;

   logic          dm_req;
   logic          dm_wen;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_done;
   logic [DW-1:0] dm_rdata;
   logic          dm_stall;

   logic          mem_req;
   logic          mem_wen;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_done;

   // Arbiter side.
   modport slave (
      input  if_req, if_addr, if_flush,
      output if_done, if_rdata, if_stall,
      input  dm_req, dm_wen, dm_addr, dm_wdata,
      output dm_done, dm_rdata, dm_stall,
      output mem_req, mem_wen, mem_addr, mem_wdata,
      input  mem_rdata, mem_done
   );

   // Clients and backend side.
   modport master (
      output if_req, if_addr, if_flush,
      input  if_done, if_rdata, if_stall,
      output dm_req, dm_wen, dm_addr, dm_wdata,
      input  dm_done, dm_rdata, dm_stall,
      input  mem_req, mem_wen, mem_addr, mem_wdata,
      output mem_rdata, mem_done
   );

endinterface

// File: rtl/mem_arbiter_starve.sv
// Saturating count of data grants won while fetch was waiting.
module mem_arbiter_starve #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned CW         = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam logic [CW-1:0] CntMax = CW'(STARVE_MAX);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat = (cnt_q == CntMax);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory port between instruction fetch and data access.
// Data wins ties unless fetch has been passed over STARVE_MAX times in a row.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned AW         = 16,
   parameter int unsigned DW         = 16,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned CW         = 3
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   arb_state_e    state_q, state_d;
   logic          flush_pend_q, flush_pend_d;
   logic          if_done_q, if_done_d, dm_done_q, dm_done_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
   logic          mem_req_q, mem_req_d, mem_wen_q, mem_wen_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          grant, starve_inc, starve_clr, starve_sat;
   client_e       grant_client;

   mem_arbiter_starve #(
      .STARVE_MAX (STARVE_MAX),
      .CW         (CW)
   ) u_starve (
      .clk (clk),
      .rst (rst),
      .inc (starve_inc),
      .clr (starve_clr),
      .sat (starve_sat)
   );

   always_comb begin
      state_d      = state_q;
      flush_pend_d = flush_pend_q;
      if_done_d    = 1'b0;
      dm_done_d    = 1'b0;
      if_rdata_d   = if_rdata_q;
      dm_rdata_d   = dm_rdata_q;
      mem_req_d    = 1'b0;
      mem_wen_d    = mem_wen_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      grant        = 1'b0;
      grant_client = ClientI;
      starve_inc   = 1'b0;
      starve_clr   = 1'b0;

      unique case (state_q)
         StIdle: begin
            starve_clr = ~bus.if_req;
            // In a done cycle the requests are still the stale ones just served: grant nothing.
            if (!if_done_q && !dm_done_q) begin
               if (bus.dm_req && (!bus.if_req || !starve_sat)) begin
                  grant        = 1'b1;
                  grant_client = ClientD;
               end else if (bus.if_req && !bus.if_flush) begin
                  grant        = 1'b1;
                  grant_client = ClientI;
               end
            end
            if (grant) begin
               mem_req_d = 1'b1;
               if (grant_client == ClientD) begin
                  state_d     = StServeD;
                  mem_wen_d   = bus.dm_wen;
                  mem_addr_d  = bus.dm_addr;
                  mem_wdata_d = bus.dm_wdata;
                  starve_inc  = bus.if_req;
               end else begin
                  state_d     = StServeI;
                  mem_wen_d   = 1'b0;
                  mem_addr_d  = bus.if_addr;
                  mem_wdata_d = '0;
                  starve_clr  = 1'b1;
               end
            end
         end
         StServeI: begin
            if (bus.if_flush) begin
               flush_pend_d = 1'b1;
            end
            if (bus.mem_done) begin
               state_d      = StIdle;
               flush_pend_d = 1'b0;
               if (!flush_pend_q && !bus.if_flush) begin
                  if_done_d  = 1'b1;
                  if_rdata_d = bus.mem_rdata;
               end
            end
         end
         StServeD: begin
            if (bus.mem_done) begin
               state_d   = StIdle;
               dm_done_d = 1'b1;
               if (!mem_wen_q) begin
                  dm_rdata_d = bus.mem_rdata;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         flush_pend_q <= 1'b0;
         if_done_q    <= 1'b0;
         dm_done_q    <= 1'b0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
         mem_req_q    <= 1'b0;
         mem_wen_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
         if_done_q    <= if_done_d;
         dm_done_q    <= dm_done_d;
         if_rdata_q   <= if_rdata_d;
         dm_rdata_q   <= dm_rdata_d;
         mem_req_q    <= mem_req_d;
         mem_wen_q    <= mem_wen_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign bus.if_done   = if_done_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_stall  = bus.if_req & ~if_done_q;
   assign bus.dm_done   = dm_done_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.dm_stall  = bus.dm_req & ~dm_done_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_wen   = mem_wen_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed client traffic, a behavioural backend, and a
// transaction-level model compared against the DUT outputs every cycle.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam int          STARVE_MAX = 4;
   localparam int unsigned CW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   chk_en = 1'b0;
   string glog = "";

   mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_arbiter #(
      .AW         (AW),
      .DW         (DW),
      .STARVE_MAX (STARVE_MAX),
      .CW         (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_str(input string name, input string act, input string exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got '%s', expected '%s'", name, act, exp);
      end
   endtask

   // ---------------- backend: fixed latency, word memory ----------------
   logic [15:0] bk_mem [0:1023];
   int          bk_lat = 1;
   bit          bk_busy = 1'b0;
   int          bk_left = 0;
   logic        bk_wen;
   logic [15:0] bk_addr, bk_wdata;
   bit          inj_done = 1'b0;

   always begin
      @(posedge clk);
      #2;
      bus.mem_done  = 1'b0;
      bus.mem_rdata = 16'hA5A5;
      if (rst) begin
         bk_busy = 1'b0;
      end else if (bus.mem_req) begin
         bk_busy  = 1'b1;
         bk_left  = bk_lat;
         bk_wen   = bus.mem_wen;
         bk_addr  = bus.mem_addr;
         bk_wdata = bus.mem_wdata;
      end
      if (bk_busy) begin
         if (bk_left == 0) begin
            bus.mem_done = 1'b1;
            bk_busy = 1'b0;
            if (bk_wen) bk_mem[bk_addr[10:1]] = bk_wdata;
            else bus.mem_rdata = bk_mem[bk_addr[10:1]];
         end else begin
            bk_left--;
         end
      end
      if (inj_done) begin
         bus.mem_done  = 1'b1;
         bus.mem_rdata = 16'hFFFF;
      end
   end

   // ---------------- transaction-level model ----------------
   int          m_owner = 0;  // 0 port free, 1 fetch owns it, 2 data owns it
   bit          m_flushed, m_if_done, m_dm_done, m_mem_req, m_wen;
   int          m_cnt;
   logic [15:0] m_if_rdata, m_dm_rdata, m_addr, m_wdata;

   task automatic model_step();
      bit was_done;
      if (rst) begin
         m_owner = 0; m_flushed = 0; m_cnt = 0; m_if_done = 0; m_dm_done = 0;
         m_mem_req = 0; m_wen = 0; m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_dm_rdata = 0;
         return;
      end
      was_done  = m_if_done || m_dm_done;
      m_if_done = 0;
      m_dm_done = 0;
      m_mem_req = 0;
      if (m_owner == 0) begin
         if (!bus.if_req) m_cnt = 0;
         if (!was_done) begin
            if (bus.dm_req && !(bus.if_req && m_cnt == STARVE_MAX)) begin
               m_owner = 2; m_mem_req = 1;
               m_wen = bus.dm_wen; m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
               if (bus.if_req) m_cnt = (m_cnt + 1 > STARVE_MAX) ? STARVE_MAX : m_cnt + 1;
            end else if (bus.if_req && !bus.if_flush) begin
               m_owner = 1; m_mem_req = 1; m_wen = 0; m_addr = bus.if_addr; m_cnt = 0;
            end
         end
      end else if (m_owner == 1) begin
         if (bus.if_flush) m_flushed = 1;
         if (bus.mem_done) begin
            if (!m_flushed) begin
               m_if_done = 1;
               m_if_rdata = bus.mem_rdata;
            end
            m_flushed = 0;
            m_owner = 0;
         end
      end else if (bus.mem_done) begin
         m_dm_done = 1;
         if (!m_wen) m_dm_rdata = bus.mem_rdata;
         m_owner = 0;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("if_done", bus.if_done, m_if_done);
         check("if_rdata", bus.if_rdata, m_if_rdata);
         check("if_stall", bus.if_stall, bus.if_req && !m_if_done);
         check("dm_done", bus.dm_done, m_dm_done);
         check("dm_rdata", bus.dm_rdata, m_dm_rdata);
         check("dm_stall", bus.dm_stall, bus.dm_req && !m_dm_done);
         check("mem_req", bus.mem_req, m_mem_req);
         check("mem_wen", bus.mem_wen, m_wen);
         check("mem_addr", bus.mem_addr, m_addr);
         if (m_wen) check("mem_wdata", bus.mem_wdata, m_wdata);
         if (bus.if_done) glog = {glog, "I"};
         if (bus.dm_done) glog = {glog, "D"};
      end
      model_step();
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ev(input int sel, input string name, output int at_cyc);
      bit hit = 1'b0;
      at_cyc = -1;
      for (int i = 0; i < 50 && !hit; i++) begin
         @(negedge clk);
         case (sel)
            0:       hit = bus.mem_req;
            1:       hit = bus.if_done;
            default: hit = bus.dm_done;
         endcase
         if (hit) at_cyc = cyc;
      end
      if (!hit) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got no event, expected one within 50 cycles", name);
      end
   endtask

   initial begin
      int t0, t_mr, t_d, nd;
      bit seen_i;
      for (int i = 0; i < 1024; i++) bk_mem[i] = 16'(i * 3 + 16'h0100);
      bk_mem[10'h020] = 16'hBEEF;  // 0x0040
      bk_mem[10'h080] = 16'hC0DE;  // 0x0100
      bk_mem[10'h100] = 16'h0BAD;  // 0x0200
      bk_mem[10'h008] = 16'h7777;  // 0x0010
      bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
      bus.dm_req = 0; bus.dm_wen = 0; bus.dm_addr = 0; bus.dm_wdata = 0;

      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_state", dut.state_q, StIdle);
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
      check("rst_dones", {bus.if_done, bus.dm_done}, 0);
      tick();
      rst = 1'b0;

      // 1: fetch alone, backend latency 3
      tick();
      bk_lat = 3;
      bus.if_req = 1; bus.if_addr = 16'h0040;
      t0 = cyc;
      wait_ev(0, "t1_mem_req", t_mr);
      check("t1_req_latency", t_mr - t0, 1);
      wait_ev(1, "t1_if_done", t_d);
      check("t1_done_latency", t_d - t_mr, 4);
      check("t1_if_rdata", bus.if_rdata, 16'hBEEF);
      tick();
      bus.if_req = 0;

      // 2: simultaneous fetch and data read, data first
      tick();
      glog = "";
      bk_lat = 2;
      bus.if_req = 1; bus.if_addr = 16'h0040;
      bus.dm_req = 1; bus.dm_wen = 0; bus.dm_addr = 16'h0010;
      wait_ev(2, "t2_dm_done", t_d);
      check("t2_if_stall", bus.if_stall, 1);
      tick();
      bus.dm_req = 0;
      wait_ev(1, "t2_if_done", t_d);
      check("t2_dm_rdata", bus.dm_rdata, 16'h7777);
      tick();
      bus.if_req = 0;
      check_str("t2_order", glog, "DI");

      // 3: data held for six accesses while fetch waits
      tick();
      glog = "";
      bk_lat = 1;
      bus.if_req = 1; bus.dm_req = 1; bus.dm_addr = 16'h0010;
      nd = 0;
      seen_i = 0;
      for (int k = 0; k < 200 && nd < 6; k++) begin
         @(negedge clk);
         if (bus.dm_done) begin
            nd++;
            if (nd == 4) check("t3_cnt_sat", dut.u_starve.cnt_q, 4);
         end
         if (bus.if_done && !seen_i) begin
            seen_i = 1;
            check("t3_cnt_after_i", dut.u_starve.cnt_q, 0);
         end
      end
      check("t3_data_grants", nd, 6);
      tick();
      bus.dm_req = 0;
      wait_ev(1, "t3_if_done", t_d);
      tick();
      bus.if_req = 0;
      check_str("t3_order", glog.substr(0, 5), "DDDDID");

      // 4: fetch flushed one cycle after launch, then redirected fetch
      tick();
      glog = "";
      bk_lat = 3;
      bus.if_req = 1; bus.if_addr = 16'h0200;
      wait_ev(0, "t4_launch1", t_mr);
      check("t4_addr1", bus.mem_addr, 16'h0200);
      tick();
      bus.if_flush = 1; bus.if_addr = 16'h0100;
      tick();
      bus.if_flush = 0;
      wait_ev(0, "t4_launch2", t_mr);
      check("t4_addr2", bus.mem_addr, 16'h0100);
      wait_ev(1, "t4_if_done", t_d);
      check("t4_if_rdata", bus.if_rdata, 16'hC0DE);
      tick();
      bus.if_req = 0;
      check_str("t4_pulses", glog, "I");

      // 5: write then read back
      tick();
      bk_lat = 2;
      bus.dm_req = 1; bus.dm_wen = 1; bus.dm_addr = 16'h0008; bus.dm_wdata = 16'h1234;
      wait_ev(0, "t5_launch_w", t_mr);
      check("t5_wen_w", bus.mem_wen, 1);
      check("t5_wdata", bus.mem_wdata, 16'h1234);
      wait_ev(2, "t5_done_w", t_d);
      check("t5_rdata_after_w", bus.dm_rdata, 16'h7777);
      tick();
      bus.dm_req = 0; bus.dm_wen = 0; bus.dm_wdata = 0;
      tick();
      bus.dm_req = 1;
      wait_ev(0, "t5_launch_r", t_mr);
      check("t5_wen_r", bus.mem_wen, 0);
      wait_ev(2, "t5_done_r", t_d);
      check("t5_rdata_after_r", bus.dm_rdata, 16'h1234);
      tick();
      bus.dm_req = 0;

      // 6: reset in the middle of a data access, then a stray completion
      tick();
      bk_lat = 5;
      bus.dm_req = 1; bus.dm_addr = 16'h0010;
      wait_ev(0, "t6_launch", t_mr);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.dm_req = 0;
      @(negedge clk);
      check("t6_state", dut.state_q, StIdle);
      check("t6_mem", {bus.mem_req, bus.mem_wen, bus.mem_addr}, 0);
      check("t6_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
      check("t6_done_stall", {bus.if_done, bus.dm_done, bus.if_stall, bus.dm_stall}, 0);
      tick();
      inj_done = 1'b1;
      tick();
      inj_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t6_no_done", {bus.if_done, bus.dm_done}, 0);
         check("t6_dm_rdata", bus.dm_rdata, 0);
      end
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
